nod: RTL and testbench
======================

// Module: nod
// PURPOSE
//   Nearest-One Detector for the iterative logarithmic multiplier (ILM) datapath.
//   Maps an unsigned operand to the one-hot power of two nearest to it.
//   The ILM uses this as the base term of its approximation.
//   The result is registered: one clock, synchronous active-high reset.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>= 2)
// PORTS
//   clk  input   1      clock, all state updates on rising edge
//   rst  input   1      synchronous active-high reset
//   A    input   WIDTH  unsigned operand, sampled every rising edge
//   O    output  WIDTH  registered one-hot nearest power of two of A (0 if A==0)
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is synchronous and active-high.
//   - Reset: while rst=1 at a rising edge, O <= 0. Reset has priority over the A update.
//   - Latency: exactly 1 cycle. O after edge n = f(A sampled at edge n).
//   - No handshake and no enable; a new A is accepted every cycle (throughput 1/clk).
//   - f(A), combinational core:
//       k = index of the most significant 1 in A (leading-one detect).
//       if A==0 -> 0
//       else if k==0 -> 1
//       else if A[k-1]==0 -> 1<<k       (round down)
//       else -> 1<<(k+1)               (round up; ties such as 3, 6, 48 go up)
//   - Saturation: if k==WIDTH-1 and A[WIDTH-2]==1, the result (1<<WIDTH) does not fit.
//     O saturates to 1<<(WIDTH-1). For WIDTH=8, A in 192..255 gives O=8'h80.
//   - O is always zero or exactly one-hot; no other values are legal.
//   - Only the bit directly below the leading one affects rounding; lower bits are ignored.
//   - Purely unsigned arithmetic; no X propagation from an unused lower bit.
//   - Reset mid-stream: the edge with rst=1 yields O=0. The first edge after rst
//     deasserts loads f(A) normally. No other internal state exists.
//   - Implementation: parameterised priority encoder plus one-hot generator, or an
//     equivalent generate loop. O is the sole flop bank.
// TESTING
//   1. rst=1 for 2 edges with A=8'hFF -> O=0. Release rst -> O=8'h80 one edge later.
//   2. A=0 -> 0; A=1 -> 1; A=2 -> 2; A=7 -> 8. Each A is held 1 cycle; O is checked next edge.
//   3. A=8'b01101100 (108) -> 128; A=73 -> 64; A=5 -> 4; A=48 (tie) -> 64.
//   4. A=8'b10101010 (170) -> 128; A=128 -> 128; A=255 -> 128 (saturation).
//   5. Exhaustive sweep A=0..255, back-to-back each cycle, against the reference model
//      with 1-cycle delay. Also assert on every cycle that O is one-hot or zero.
//   6. Assert rst for one cycle in the middle of the sweep -> O=0 on that edge.
//      The following edge resumes with the correct f(A).

Source files
------------

// File: rtl/nod.sv
// Nearest-one detector: maps an unsigned operand to the nearest one-hot power of two,
// registered with a single-cycle latency. Ties round up; results past the MSB saturate.
module nod #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] O
);

    logic [WIDTH-1:0] lead;
    logic [WIDTH-1:0] nearest;
    logic             seen;
    logic             round_up;

    // Leading-one detect as a one-hot vector, scanning down from the MSB.
    always_comb begin
        lead = '0;
        seen = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            lead[i] = A[i] & ~seen;
            seen    = seen | A[i];
        end
    end

    // Only the bit directly below the leading one decides rounding.
    assign round_up = |(lead[WIDTH-1:1] & A[WIDTH-2:0]);

    always_comb begin
        nearest = lead;
        if (round_up && !lead[WIDTH-1]) begin
            nearest = lead << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            O <= '0;
        end else begin
            O <= nearest;
        end
    end

endmodule

// File: tb/tb_nod.sv
// Directed and exhaustive bench for the nearest-one detector; the reference model rounds
// by comparing distances to the neighbouring powers of two.
module tb_nod;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] O;

    int n_checks = 0;
    int n_pass   = 0;
    bit monitor  = 1'b0;

    nod #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .O   (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [7:0] ref_nod(input int a);
        int p;
        int r;
        if (a == 0) return 8'd0;
        p = 1;
        while (p * 2 <= a) p = p * 2;
        // Nearer of p and 2p; equal distance goes to 2p.
        r = ((a - p) >= (2 * p - a)) ? 2 * p : p;
        if (r > 128) r = 128;
        return r[7:0];
    endfunction

    // Apply one operand for one cycle and check the registered result after the edge.
    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] exp);
        A = a;
        @(posedge clk);
        #1;
        check(tag, O, exp);
    endtask

    always @(negedge clk) begin
        if (monitor) check("onehot0", {7'd0, $onehot0(O)}, 8'd1);
    end

    initial begin
        rst = 1'b1;
        A   = 8'hFF;
        @(posedge clk);
        #1;
        check("rst_edge1", O, 8'h00);
        @(posedge clk);
        #1;
        check("rst_edge2", O, 8'h00);
        monitor = 1'b1;
        rst = 1'b0;
        step("rst_release", 8'hFF, 8'h80);

        step("a0",   8'd0,   8'd0);
        step("a1",   8'd1,   8'd1);
        step("a2",   8'd2,   8'd2);
        step("a7",   8'd7,   8'd8);
        step("a3",   8'd3,   8'd4);
        step("a108", 8'd108, 8'd128);
        step("a73",  8'd73,  8'd64);
        step("a5",   8'd5,   8'd4);
        step("a48",  8'd48,  8'd64);
        step("a6",   8'd6,   8'd8);
        step("a170", 8'd170, 8'd128);
        step("a128", 8'd128, 8'd128);
        step("a191", 8'd191, 8'd128);
        step("a192", 8'd192, 8'd128);
        step("a255", 8'd255, 8'd128);
        step("a95",  8'd95,  8'd64);
        step("a96",  8'd96,  8'd128);

        for (int a = 0; a < 256; a++) begin
            if (a == 100) begin
                rst = 1'b1;
                step("sweep_rst", 8'(a), 8'd0);
                rst = 1'b0;
            end
            step("sweep", 8'(a), ref_nod(a));
        end

        monitor = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
